riio_gpi_sync_debounce: RTL and testbench

- Core-side receive stage directly downstream of the EG1D80V GPI pad cell with pull-down.
- Drives the pad's input-enable and Schmitt-trigger controls.
- Consumes the pad data output, then synchronises it into the core clock domain and debounces it with a qualification counter.
- Outputs a clean level plus single-cycle rise/fall pulses for interrupt and GPIO logic.

---
 rtl/riio_gpi_sync_debounce_pkg.sv | 14 +
 rtl/riio_gpi_sync_debounce_if.sv | 44 ++++
 rtl/riio_gpi_sync_debounce_sync.sv | 20 ++
 rtl/riio_gpi_sync_debounce.sv | 147 ++++++++++++++
 tb/tb_riio_gpi_sync_debounce.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/riio_gpi_sync_debounce_pkg.sv
// Shared types and constants for the GPI receive stage.
package riio_gpi_pkg;

  typedef enum logic [1:0] {
    OFF,
    BLANK,
    STABLE,
    QUALIFY
  } gpi_state_t;

  localparam int GPI_SYNC_MIN = 2;
  localparam int GPI_GLITCH_W = 8;

endpackage

// File: rtl/riio_gpi_sync_debounce_if.sv
// Pad-control and debounced-level bundle for the GPI stage.
// Glitch counter signals exist only with RIIO_GPI_GLITCH_CNT_EN.
interface riio_gpi_sync_debounce_if;
  import riio_gpi_pkg::*;

  logic       EN_I;
  logic [1:0] STE_CFG_I;
  logic       IE_O;
  logic [1:0] STE_O;
  logic       DI_I;
  logic       LEVEL_O;
  logic       RISE_O;
  logic       FALL_O;
  logic       BUSY_O;
`ifdef RIIO_GPI_GLITCH_CNT_EN
  logic                    GLITCH_CLR_I;
  logic [GPI_GLITCH_W-1:0] GLITCH_CNT_O;

  modport master (
    output EN_I, STE_CFG_I, DI_I, GLITCH_CLR_I,
    input  IE_O, STE_O, LEVEL_O, RISE_O,
    input  FALL_O, BUSY_O, GLITCH_CNT_O
  );

  modport slave (
    input  EN_I, STE_CFG_I, DI_I, GLITCH_CLR_I,
    output IE_O, STE_O, LEVEL_O, RISE_O,
    output FALL_O, BUSY_O, GLITCH_CNT_O
  );
`else
  modport master (
    output EN_I, STE_CFG_I, DI_I,
    input  IE_O, STE_O, LEVEL_O, RISE_O,
    input  FALL_O, BUSY_O
  );

  modport slave (
    input  EN_I, STE_CFG_I, DI_I,
    output IE_O, STE_O, LEVEL_O, RISE_O,
    output FALL_O, BUSY_O
  );
`endif

endinterface

// File: rtl/riio_gpi_sync_debounce_sync.sv
// Multi-flop synchroniser for the asynchronous pad data.
module riio_gpi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/riio_gpi_sync_debounce.sv
// GPI receive stage: pad control, sync, debounce, edge pulses.
// Define RIIO_GPI_GLITCH_CNT_EN to add the glitch counter.
module riio_gpi_sync_debounce
  import riio_gpi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input logic CLK_I,
  input logic RST_I,
  riio_gpi_sync_debounce_if.slave gpi
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam int BLK_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEB_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LOAD =
    BLK_W'(SYNC_STAGES + 1);

  gpi_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ie_q;
  logic [1:0]       ste_q;
  logic             s;

  riio_gpi_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (CLK_I),
    .rst (RST_I),
    .d   (gpi.DI_I),
    .q   (s)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= OFF;
      cnt_q   <= '0;
      blk_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ie_q    <= 1'b0;
      ste_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ie_q    <= gpi.EN_I;
      ste_q   <= gpi.STE_CFG_I;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Disable drops the level silently: no FALL pulse.
    if (!gpi.EN_I) begin
      state_d = OFF;
      cnt_d   = '0;
      blk_d   = '0;
      level_d = 1'b0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d = BLANK;
          blk_d   = BLK_LOAD;
          cnt_d   = '0;
          level_d = 1'b0;
        end
        BLANK: begin
          blk_d = blk_q - BLK_W'(1);
          if (blk_q == BLK_W'(1)) begin
            level_d = s;
            state_d = STABLE;
          end
        end
        STABLE: begin
          if (s != level_q) begin
            if (DEB_CYCLES == 1) begin
              level_d = s;
              rise_d  = s;
              fall_d  = !s;
            end else begin
              state_d = QUALIFY;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        QUALIFY: begin
          if (s == level_q) begin
            cnt_d   = '0;
            state_d = STABLE;
          end else if (cnt_q == CNT_MAX) begin
            level_d = s;
            rise_d  = s;
            fall_d  = !s;
            cnt_d   = '0;
            state_d = STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  assign gpi.IE_O    = ie_q;
  assign gpi.STE_O   = ste_q;
  assign gpi.LEVEL_O = level_q;
  assign gpi.RISE_O  = rise_q;
  assign gpi.FALL_O  = fall_q;
  assign gpi.BUSY_O  = (state_q == BLANK) ||
                       (state_q == QUALIFY);

`ifdef RIIO_GPI_GLITCH_CNT_EN
  logic                    glitch_evt;
  logic [GPI_GLITCH_W-1:0] gcnt_q;

  assign glitch_evt = gpi.EN_I &&
                      (state_q == QUALIFY) &&
                      (s == level_q);

  always_ff @(posedge CLK_I) begin
    if (RST_I || gpi.GLITCH_CLR_I)
      gcnt_q <= '0;
    else if (glitch_evt && (gcnt_q != '1))
      gcnt_q <= gcnt_q + GPI_GLITCH_W'(1);
  end

  assign gpi.GLITCH_CNT_O = gcnt_q;
`endif

endmodule

// File: tb/tb_riio_gpi_sync_debounce.sv
// Directed bench: SYNC_STAGES=2, DEB_CYCLES=4 and DEB_CYCLES=1.
module tb_riio_gpi_sync_debounce;

  logic clk = 1'b0;
  logic rst;
  int   npass = 0;
  int   ntot  = 0;
  int   rise_n = 0, fall_n = 0;
  int   rise1_n = 0, fall1_n = 0;

  always #5 clk = ~clk;

  riio_gpi_sync_debounce_if bus ();
  riio_gpi_sync_debounce_if bus1 ();

  riio_gpi_sync_debounce #(
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4)
  ) u_dut (
    .CLK_I (clk),
    .RST_I (rst),
    .gpi   (bus)
  );

  riio_gpi_sync_debounce #(
    .SYNC_STAGES (2),
    .DEB_CYCLES  (1)
  ) u_dut1 (
    .CLK_I (clk),
    .RST_I (rst),
    .gpi   (bus1)
  );

  always @(negedge clk) begin
    if (bus.RISE_O)  rise_n++;
    if (bus.FALL_O)  fall_n++;
    if (bus1.RISE_O) rise1_n++;
    if (bus1.FALL_O) fall1_n++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  initial begin
    rst            = 1'b1;
    bus.EN_I       = 1'b1;
    bus.DI_I       = 1'b1;
    bus.STE_CFG_I  = 2'b00;
    bus1.EN_I      = 1'b1;
    bus1.DI_I      = 1'b0;
    bus1.STE_CFG_I = 2'b00;
`ifdef RIIO_GPI_GLITCH_CNT_EN
    bus.GLITCH_CLR_I  = 1'b0;
    bus1.GLITCH_CLR_I = 1'b0;
`endif
    tick(3);
    chk("rst_ie",    8'(bus.IE_O),    8'd0);
    chk("rst_ste",   8'(bus.STE_O),   8'd0);
    chk("rst_level", 8'(bus.LEVEL_O), 8'd0);
    chk("rst_rise",  8'(bus.RISE_O),  8'd0);
    chk("rst_fall",  8'(bus.FALL_O),  8'd0);
    chk("rst_busy",  8'(bus.BUSY_O),  8'd0);

    // Release with DI already high
    rst = 1'b0;
    tick();
    chk("en_ie",    8'(bus.IE_O),   8'd1);
    chk("blank_b0", 8'(bus.BUSY_O), 8'd1);
    tick();
    chk("blank_b1", 8'(bus.BUSY_O), 8'd1);
    tick();
    chk("blank_b2", 8'(bus.BUSY_O), 8'd1);
    chk("blank_lv", 8'(bus.LEVEL_O), 8'd0);
    tick();
    chk("blank_end", 8'(bus.BUSY_O), 8'd0);
    chk("init_lv",   8'(bus.LEVEL_O), 8'd1);
    tick(2);
    chk("init_norise", 8'(rise_n), 8'd0);

    // Clean falling edge
    bus.DI_I = 1'b0;
    tick(5);
    chk("fall_pre_lv",  8'(bus.LEVEL_O), 8'd1);
    chk("fall_qual",    8'(bus.BUSY_O),  8'd1);
    tick();
    chk("fall_lv",      8'(bus.LEVEL_O), 8'd0);
    chk("fall_pulse",   8'(bus.FALL_O),  8'd1);
    chk("fall_norise",  8'(bus.RISE_O),  8'd0);
    tick();
    chk("fall_pulse_end", 8'(bus.FALL_O), 8'd0);
    tick(8);
    chk("fall_count", 8'(fall_n), 8'd1);

    // Clean rising edge
    bus.DI_I = 1'b1;
    tick(5);
    chk("rise_pre_lv", 8'(bus.LEVEL_O), 8'd0);
    tick();
    chk("rise_lv",    8'(bus.LEVEL_O), 8'd1);
    chk("rise_pulse", 8'(bus.RISE_O),  8'd1);
    tick();
    chk("rise_pulse_end", 8'(bus.RISE_O), 8'd0);
    tick(8);
    chk("rise_count", 8'(rise_n), 8'd1);

    // Back low, then a 2-cycle glitch
    bus.DI_I = 1'b0;
    tick(10);
    chk("low_again", 8'(bus.LEVEL_O), 8'd0);
    chk("fall_count2", 8'(fall_n), 8'd2);
    bus.DI_I = 1'b1;
    tick(2);
    bus.DI_I = 1'b0;
    tick(6);
    chk("glitch_lv",   8'(bus.LEVEL_O), 8'd0);
    chk("glitch_rise", 8'(rise_n), 8'd1);
    chk("glitch_busy", 8'(bus.BUSY_O), 8'd0);
`ifdef RIIO_GPI_GLITCH_CNT_EN
    chk("glitch_cnt1", bus.GLITCH_CNT_O, 8'd1);
`endif
    for (int i = 0; i < 299; i++) begin
      bus.DI_I = 1'b1;
      tick(2);
      bus.DI_I = 1'b0;
      tick(5);
    end
    chk("glitch_many_lv",   8'(bus.LEVEL_O), 8'd0);
    chk("glitch_many_rise", 8'(rise_n), 8'd1);
`ifdef RIIO_GPI_GLITCH_CNT_EN
    chk("glitch_sat", bus.GLITCH_CNT_O, 8'hFF);
    bus.GLITCH_CLR_I = 1'b1;
    tick();
    bus.GLITCH_CLR_I = 1'b0;
    chk("glitch_clr", bus.GLITCH_CNT_O, 8'd0);
`endif

    // Raise level, then disable during falling qualify
    bus.DI_I = 1'b1;
    tick(6);
    chk("dis_pre_lv", 8'(bus.LEVEL_O), 8'd1);
    tick(2);
    bus.DI_I = 1'b0;
    tick(4);
    chk("dis_qual", 8'(bus.BUSY_O),  8'd1);
    chk("dis_qlv",  8'(bus.LEVEL_O), 8'd1);
    bus.EN_I = 1'b0;
    tick();
    chk("dis_lv",    8'(bus.LEVEL_O), 8'd0);
    chk("dis_busy",  8'(bus.BUSY_O),  8'd0);
    chk("dis_ie",    8'(bus.IE_O),    8'd0);
    chk("dis_nofall", 8'(bus.FALL_O), 8'd0);
    tick(2);
    chk("dis_fall_n", 8'(fall_n), 8'd2);

    // Re-enable: full 3-cycle blank
    bus.EN_I = 1'b1;
    tick();
    chk("re_ie", 8'(bus.IE_O),   8'd1);
    chk("re_b0", 8'(bus.BUSY_O), 8'd1);
    tick();
    chk("re_b1", 8'(bus.BUSY_O), 8'd1);
    tick();
    chk("re_b2", 8'(bus.BUSY_O), 8'd1);
    tick();
    chk("re_end", 8'(bus.BUSY_O),  8'd0);
    chk("re_lv",  8'(bus.LEVEL_O), 8'd0);

    // STE passthrough
    bus.STE_CFG_I = 2'b10;
    chk("ste_pre", 8'(bus.STE_O), 8'd0);
    tick();
    chk("ste_post", 8'(bus.STE_O), 8'd2);

    // DEB_CYCLES=1: 1-cycle pulse passes through
    chk("d1_lv0", 8'(bus1.LEVEL_O), 8'd0);
    bus1.DI_I = 1'b1;
    tick();
    bus1.DI_I = 1'b0;
    tick();
    chk("d1_lv_t1", 8'(bus1.LEVEL_O), 8'd0);
    tick();
    chk("d1_lv_t2", 8'(bus1.LEVEL_O), 8'd1);
    chk("d1_rise",  8'(bus1.RISE_O),  8'd1);
    tick();
    chk("d1_lv_t3", 8'(bus1.LEVEL_O), 8'd0);
    chk("d1_fall",  8'(bus1.FALL_O),  8'd1);
    chk("d1_norise", 8'(bus1.RISE_O), 8'd0);
    tick(3);
    chk("d1_rise_n", 8'(rise1_n), 8'd1);
    chk("d1_fall_n", 8'(fall1_n), 8'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
